uart_rx: RTL

UART receive engine: the receiving end of the serial link driven by the team's UART transmitter.
- Consumes the oversampling tick from the shared baud generator, which is built on the counter register.
- Deserialises one start bit, D_BIT data bits (LSB first), optional parity and one stop bit.
- Presents the received word with a one-cycle done strobe and a frame error flag.

---
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bus: oversampling tick and line in, received word and status out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int D_BIT = 8
);
  logic             s_tick;
  logic             rx;
  logic [D_BIT-1:0] dout;
  logic             rx_done_tick;
  logic             frame_err;
  logic             busy;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;

  modport master (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err,
    output busy, parity_err
  );
  modport slave (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err,
    input  busy, parity_err
  );
`else
  modport master (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err,
    output busy
  );
  modport slave (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err,
    input  busy
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receive engine: start, D_BIT data (LSB first), stop; centre-sampled.
// Optional even parity bit and parity_err output under UART_RX_PARITY_EN.
module uart_rx #(
  parameter int D_BIT   = 8,
  parameter int OS_TICK = 16,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);
  localparam int CMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int SW   = $clog2(CMAX);
  localparam int NW   = $clog2(D_BIT);

  localparam logic [SW-1:0] HALF = SW'(OS_TICK / 2 - 1);
  localparam logic [SW-1:0] FULL = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] SLST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLST = NW'(D_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t           state, state_n;
  logic [SW-1:0]    s_cnt, s_cnt_n;
  logic [NW-1:0]    n_cnt, n_cnt_n;
  logic [D_BIT-1:0] shift, shift_n;
  logic [D_BIT-1:0] dout, dout_n;
  logic             done, done_n;
  logic             ferr, ferr_n;
  logic             busy;
  logic             rx_m, rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_n;
  logic             perr, perr_n;
`endif

  // Two-flop synchroniser; preset to idle-high so reset never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      s_cnt   <= '0;
      n_cnt   <= '0;
      shift   <= '0;
      dout    <= '0;
      done    <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      s_cnt   <= s_cnt_n;
      n_cnt   <= n_cnt_n;
      shift   <= shift_n;
      dout    <= dout_n;
      done    <= done_n;
      ferr    <= ferr_n;
      busy    <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_n;
      perr    <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    n_cnt_n   = n_cnt;
    shift_n   = shift;
    dout_n    = dout;
    done_n    = 1'b0;
    ferr_n    = ferr;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_n    = perr;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt == HALF) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt == FULL) begin
            shift_n = {rx_s, shift[D_BIT-1:1]};
            s_cnt_n = '0;
            if (n_cnt == NLST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_cnt_n = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_cnt == FULL) begin
            par_bit_n = rx_s;
            s_cnt_n   = '0;
            state_n   = STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt == SLST) begin
            dout_n  = shift;
            ferr_n  = ~rx_s;
            done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_n  = par_bit ^ (^shift);
`endif
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout         = dout;
  assign bus.rx_done_tick = done;
  assign bus.frame_err    = ferr;
  assign bus.busy         = busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr;
`endif

endmodule
